// File: rtl/register_dump_serializer_if.sv
// Byte stream link between the register dump serializer and its consumer (debug UART).
// Ports: o_data (8-bit byte), o_valid (byte present), i_ready (consumer takes byte this edge).
// Master drives data/valid and the slave drives ready; a byte moves on a posedge with valid && ready.
interface register_dump_serializer_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/register_dump_serializer.sv
// Snapshots the flattened register debug bus on i_start and streams it out byte by byte.
// Ports: clk/rst, i_start, i_registers_debug, stream (o_data/o_valid/i_ready), o_busy, o_done, o_byte_idx.
// First byte valid the cycle after start; one byte per cycle; data/index hold while i_ready is low.
module register_dump_serializer #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int TOTAL_BYTES   = SIZE * NUM_REGISTERS / 8,
  parameter int IDX_W         = $clog2(TOTAL_BYTES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [SIZE*NUM_REGISTERS-1:0]   i_registers_debug,
  register_dump_serializer_if.master      stream,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [IDX_W-1:0]                o_byte_idx
);

  localparam int BYTES_PER_REG = SIZE / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                    state;
  logic [SIZE*NUM_REGISTERS-1:0] snapshot;
  logic [IDX_W-1:0]              cnt;
  logic                          handshake;

  // Snapshot reordered into transmit order: register 0 first, MSB of each register first.
  logic [7:0] stream_byte [TOTAL_BYTES];

  for (genvar k = 0; k < NUM_REGISTERS; k++) begin : g_reg
    for (genvar b = 0; b < BYTES_PER_REG; b++) begin : g_byte
      assign stream_byte[k*BYTES_PER_REG + b] = snapshot[k*SIZE + SIZE-1-8*b -: 8];
    end
  end

  assign handshake = (state == SEND) && stream.i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      snapshot <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            snapshot <= i_registers_debug;
            cnt      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (cnt == IDX_W'(TOTAL_BYTES - 1)) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state; i_ready/i_start only affect the next edge.
  assign stream.o_valid = (state == SEND);
  assign stream.o_data  = (state == SEND) ? stream_byte[cnt] : 8'h00;
  assign o_busy         = (state == SEND);
  assign o_done         = (state == DONE);
  assign o_byte_idx     = cnt;

endmodule

// File: doc/register_dump_serializer.md
# register_dump_serializer

Debug-path block that takes a snapshot of the flattened register-file debug bus (`SIZE*NUM_REGISTERS` bits, register 0 in the low bits) and streams it out byte by byte over a valid/ready handshake. It sits between the register bank's debug output and the debug UART transmitter. Software on the host can therefore dump the whole architectural register state on request.

## Interface
- `SIZE`, 32, register width in bits; must be a multiple of 8.
- `NUM_REGISTERS`, 32, number of registers on the debug bus.
- `TOTAL_BYTES`, `SIZE*NUM_REGISTERS/8`, derived; bytes per dump (128 by default).
- `IDX_W`, `$clog2(TOTAL_BYTES)`, derived; byte index width.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  dump request; sampled only in IDLE.
- `i_registers_debug`  in  `SIZE*NUM_REGISTERS`  flattened registers; register k occupies bits `[k*SIZE +: SIZE]`.
- `o_data`  out  8  current byte.
- `o_valid`  out  1  `o_data` holds a byte to transfer.
- `i_ready`  in  1  downstream accepts the byte at this posedge when `o_valid` is also high.
- `o_busy`  out  1  high in SEND.
- `o_done`  out  1  one-cycle pulse after the last byte is accepted.
- `o_byte_idx`  out  `IDX_W`  index of the byte currently presented.

## Operation
- States: IDLE, SEND, DONE.
- **IDLE:**
  - On a posedge with `i_start`=1, copy all of `i_registers_debug` into an internal snapshot register.
  - Clear the byte counter and go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `o_valid`=1 and `o_data` = snapshot byte `o_byte_idx`.
  - Byte order: register 0 first, then 1, 2, and so on.
  - Within each register the most-significant byte goes first. Byte n = register `n/(SIZE/8)`, bits `[SIZE-1-8*(n%(SIZE/8)) -: 8]`.
  - On a posedge with `o_valid && i_ready`: if the counter equals `TOTAL_BYTES-1`, go to DONE and clear the counter; otherwise increment the counter and stay in SEND.
- **DONE:** lasts one cycle with `o_done`=1, `o_valid`=0, `o_busy`=0, then goes to IDLE.
- `i_start` is ignored in SEND and DONE. It is not queued.
- Snapshot: later changes on `i_registers_debug` do not affect a dump in progress. The bank updates this bus on negedge, so it is stable at the capturing posedge.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - state = IDLE
  - `o_valid`=0, `o_busy`=0, `o_done`=0
  - `o_data`=0, `o_byte_idx`=0
  - snapshot = 0
- Start latency: `i_start` sampled at edge N → `o_valid`=1 with byte 0 from edge N through at least edge N+1.
- Throughput: one byte per cycle while `i_ready`=1. Back-to-back handshakes carry no bubble.
- Backpressure: while `o_valid`=1 and `i_ready`=0, `o_data` and `o_byte_idx` hold stable. `o_valid` never drops before the handshake.
- With `i_ready` held high, the last handshake is at edge N+`TOTAL_BYTES`. `o_done` is high for the following cycle. The block is back in IDLE at edge N+`TOTAL_BYTES`+1, and `i_start` sampled there starts a new dump.
- `o_valid` is never high in IDLE or DONE. `o_done` and `o_valid` are never high together.
- All outputs are registered or decoded from registered state only. There is no combinational path from `i_ready` or `i_start` to any output.
- Reset mid-dump: the dump is abandoned with no `o_done`. The next `i_start` restarts from byte 0 with a fresh snapshot.

## Test plan
- **Reset:** assert `rst` mid-cycle with random inputs → all outputs 0 immediately. `o_valid` stays 0 while `i_start`=0.
- **Full dump, no backpressure:**
  - Stimulus: registers[k] = 0x10000000+k, `i_ready`=1, one-cycle `i_start`.
  - Expected: 128 bytes 10 00 00 00, 10 00 00 01, …, 10 00 00 1F; `o_byte_idx` runs 0..127.
  - `o_done` pulses exactly once, one cycle after the 128th handshake.
- **Backpressure:** toggle `i_ready` every cycle, plus a 10-cycle low stretch at byte 37 → `o_data` stable while stalled; exactly 128 bytes in order, with no drop or duplicate.
- **Snapshot isolation:** start with registers[k]=k, then overwrite the bus with 0xFFFFFFFF at byte 5 → the whole stream still shows the original values (for example byte 7 = 0x01).
- **Start ignored:** pulse `i_start` during SEND and during DONE → no restart and no second dump; the counter continues undisturbed.
- **Reset mid-dump:** assert `rst` at byte 50 → `o_valid`=0 at once and no `o_done`. A new `i_start` then streams from byte 0 (0x10 first).
